// File: rtl/vga_dma_pkg.sv
// Shared constants for the blitter DMA: register offsets and FSM state encoding.
package vga_dma_pkg;

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_WIDTH  = 3'd4;
    localparam logic [2:0] REG_HEIGHT = 3'd5;
    localparam logic [2:0] REG_MASK   = 3'd6;
    localparam logic [2:0] REG_START  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/vga_dma_regs.sv
// CPU-programmed blitter registers and the edge-detected start request.
module vga_dma_regs
    import vga_dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        ce_b,
    input  logic        ce2_b,
    input  logic        we_b,
    input  logic [2:0]  addr,
    input  logic [7:0]  data,
    input  logic        active,
    input  logic        start_clr,
    output logic [12:0] src,
    output logic [7:0]  dst_lo,
    output logic [7:0]  dst_hi,
    output logic [7:0]  width,
    output logic [7:0]  height,
    output logic [7:0]  mask,
    output logic        start_req
);

    logic       wr_en;
    logic       start_trig;
    logic       we_prev_reg;
    logic [7:0] src_lo_reg;
    logic [4:0] src_hi_reg;
    logic [7:0] dst_lo_reg;
    logic [7:0] dst_hi_reg;
    logic [7:0] width_reg;
    logic [7:0] height_reg;
    logic [7:0] mask_reg;
    logic       start_req_reg;

    assign wr_en = !ce_b && !ce2_b && !we_b && !active;
    // Only the first low cycle of the strobe counts, so a long strobe fires once.
    assign start_trig = wr_en && (addr == REG_START) && we_prev_reg;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            we_prev_reg   <= 1'b1;
            src_lo_reg    <= '0;
            src_hi_reg    <= '0;
            dst_lo_reg    <= '0;
            dst_hi_reg    <= '0;
            width_reg     <= '0;
            height_reg    <= '0;
            mask_reg      <= '0;
            start_req_reg <= 1'b0;
        end else begin
            we_prev_reg <= we_b;
            if (wr_en) begin
                case (addr)
                    REG_SRC_LO: src_lo_reg <= data;
                    REG_SRC_HI: src_hi_reg <= data[4:0];
                    REG_DST_LO: dst_lo_reg <= data;
                    REG_DST_HI: dst_hi_reg <= data;
                    REG_WIDTH:  width_reg  <= data;
                    REG_HEIGHT: height_reg <= data;
                    REG_MASK:   mask_reg   <= data;
                    default:    ;
                endcase
            end
            if (start_trig) begin
                start_req_reg <= 1'b1;
            end else if (start_clr) begin
                start_req_reg <= 1'b0;
            end
        end
    end

    assign src       = {src_hi_reg, src_lo_reg};
    assign dst_lo    = dst_lo_reg;
    assign dst_hi    = dst_hi_reg;
    assign width     = width_reg;
    assign height    = height_reg;
    assign mask      = mask_reg;
    assign start_req = start_req_reg;

endmodule

// File: rtl/vga_dma.sv
// Blitter DMA: copies a WxH byte rectangle from packed CRAM into VRAM (256-byte
// stride), skipping bytes whose masked value is zero.
module vga_dma
    import vga_dma_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_b,
    input  logic        i_src_ce_b,
    input  logic        i_src_ce2_b,
    output logic        o_src_re_b,
    inout  wire logic   io_src_we_b,
    inout  wire logic [12:0] io_src_addr,
    input  logic [7:0]  i_src_data,
    output logic        o_dst_we_b,
    output logic [15:0] o_dst_addr,
    output logic [7:0]  o_dst_data,
    input  logic        i_free_vbus_b,
    output logic        o_active
);

    state_t      state_reg, state_next;
    logic [12:0] src_ptr_reg, src_ptr_next;
    logic [7:0]  col_reg, col_next;
    logic [7:0]  row_reg, row_next;
    logic [7:0]  data_reg, data_next;
    logic        start_clr;

    logic [12:0] src;
    logic [7:0]  dst_lo;
    logic [7:0]  dst_hi;
    logic [7:0]  width;
    logic [7:0]  height;
    logic [7:0]  mask;
    logic        start_req;

    logic        active;
    logic [7:0]  masked;
    logic [7:0]  col_inc;
    logic [7:0]  row_inc;
    logic [15:0] dst_addr;

    vga_dma_regs u_regs (
        .clk       (i_clk),
        .rst_b     (i_rst_b),
        .ce_b      (i_src_ce_b),
        .ce2_b     (i_src_ce2_b),
        .we_b      (io_src_we_b),
        .addr      (io_src_addr[2:0]),
        .data      (i_src_data),
        .active    (active),
        .start_clr (start_clr),
        .src       (src),
        .dst_lo    (dst_lo),
        .dst_hi    (dst_hi),
        .width     (width),
        .height    (height),
        .mask      (mask),
        .start_req (start_req)
    );

    assign active   = (state_reg != IDLE);
    assign masked   = data_reg & mask;
    assign col_inc  = col_reg + 8'd1;
    assign row_inc  = row_reg + 8'd1;
    // Each address byte wraps on its own; the row never carries into the bank bit.
    assign dst_addr = {dst_hi + row_reg, dst_lo + col_reg};

    always_ff @(posedge i_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_reg   <= IDLE;
            src_ptr_reg <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            src_ptr_reg <= src_ptr_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            data_reg    <= data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        src_ptr_next = src_ptr_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        data_next    = data_reg;
        start_clr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_req) begin
                    start_clr = 1'b1;
                    if (width != 8'd0 && height != 8'd0) begin
                        col_next     = 8'd0;
                        row_next     = 8'd0;
                        src_ptr_next = src;
                        state_next   = READ;
                    end
                end
            end
            READ: begin
                data_next  = i_src_data;
                state_next = WRITE;
            end
            WRITE: begin
                // A busy video bus simply holds every output of this cycle.
                if (!i_free_vbus_b) begin
                    src_ptr_next = src_ptr_reg + 13'd1;
                    state_next   = READ;
                    if (col_inc == width) begin
                        col_next = 8'd0;
                        row_next = row_inc;
                        if (row_inc == height) begin
                            state_next = IDLE;
                        end
                    end else begin
                        col_next = col_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_active    = active;
    assign o_src_re_b  = active ? (state_reg != READ) : 1'bz;
    assign io_src_we_b = active ? 1'b1 : 1'bz;
    assign io_src_addr = active ? src_ptr_reg : 13'bz;
    assign o_dst_addr  = active ? dst_addr : 16'bz;
    assign o_dst_data  = (state_reg == WRITE) ? masked : 8'bz;
    assign o_dst_we_b  = !((state_reg == WRITE) && !i_free_vbus_b && (masked != 8'd0));

endmodule

// File: tb/tb_vga_dma.sv
// Scoreboard bench for vga_dma: directed copies with hand-derived VRAM writes.
module tb_vga_dma;

    logic        clk;
    logic        rst_b;
    logic        cpu_ce_b;
    logic        cpu_we_b;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        free_vbus_b;

    wire         src_we_w;
    wire  [12:0] src_addr_w;
    logic [7:0]  src_data;
    logic        src_re_b;
    logic        dst_we_b;
    logic [15:0] dst_addr;
    logic [7:0]  dst_data;
    logic        active;

    logic [7:0]  cram [0:8191];

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    int tests = 0;
    int fails = 0;

    // CPU side drivers back off whenever the DMA owns the bus.
    assign src_we_w   = active ? 1'bz : cpu_we_b;
    assign src_addr_w = active ? 13'bz : cpu_addr;
    assign src_data   = active ? cram[src_addr_w] : cpu_data;

    vga_dma dut (
        .i_clk         (clk),
        .i_rst_b       (rst_b),
        .i_src_ce_b    (cpu_ce_b),
        .i_src_ce2_b   (src_addr_w[3]),
        .o_src_re_b    (src_re_b),
        .io_src_we_b   (src_we_w),
        .io_src_addr   (src_addr_w),
        .i_src_data    (src_data),
        .o_dst_we_b    (dst_we_b),
        .o_dst_addr    (dst_addr),
        .o_dst_data    (dst_data),
        .i_free_vbus_b (free_vbus_b),
        .o_active      (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every VRAM strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_b && dst_we_b == 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr=%h data=%h expected none", dst_addr, dst_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                $display("[TB] write addr=%h data=%h (expect %h/%h)", dst_addr, dst_data, e.a, e.d);
                check("wr_addr", {16'h0, dst_addr}, {16'h0, e.a});
                check("wr_data", {24'h0, dst_data}, {24'h0, e.d});
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic write_reg(input logic [2:0] idx, input logic [7:0] val);
        @(negedge clk);
        #1;
        cpu_addr = {10'd0, idx};
        cpu_data = val;
        cpu_ce_b = 1'b0;
        cpu_we_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        cpu_we_b = 1'b1;
        cpu_ce_b = 1'b1;
    endtask

    task automatic prog(input logic [15:0] s, input logic [15:0] d, input logic [7:0] w,
                        input logic [7:0] h, input logic [7:0] m);
        write_reg(3'd0, s[7:0]);
        write_reg(3'd1, s[15:8]);
        write_reg(3'd2, d[7:0]);
        write_reg(3'd3, d[15:8]);
        write_reg(3'd4, w);
        write_reg(3'd5, h);
        write_reg(3'd6, m);
    endtask

    // Issue START with the strobe low for 'hold' edges; returns active cycles consumed.
    task automatic do_start(input int hold, input logic exp_act, output int cnt);
        @(negedge clk);
        #1;
        cpu_addr = 13'd7;
        cpu_data = 8'hA5;
        cpu_ce_b = 1'b0;
        cpu_we_b = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("lat_pre", {31'd0, active}, 32'd0);
        if (hold == 1) begin
            #1;
            cpu_we_b = 1'b1;
            cpu_ce_b = 1'b1;
        end
        @(negedge clk);
        check("lat_rise", {31'd0, active}, {31'd0, exp_act});
        cnt = active ? 1 : 0;
        if (hold == 2) begin
            #1;
            cpu_we_b = 1'b1;
            cpu_ce_b = 1'b1;
        end
        if (hold >= 3) begin
            @(negedge clk);
            if (active) cnt++;
            #1;
            cpu_we_b = 1'b1;
            cpu_ce_b = 1'b1;
        end
    endtask

    task automatic run_xfer(input int start_cnt, input int stall_at, input logic [15:0] stall_addr,
                            input logic [7:0] stall_data, output int cycles);
        int guard;
        cycles = start_cnt;
        guard = 0;
        while (active && guard < 5000) begin
            if (cycles == stall_at) begin
                #1 free_vbus_b = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    cycles++;
                    check("stall_we", {31'd0, dst_we_b}, 32'd1);
                    check("stall_addr", {16'd0, dst_addr}, {16'd0, stall_addr});
                    check("stall_data", {24'd0, dst_data}, {24'd0, stall_data});
                end
                @(posedge clk);
                #1 free_vbus_b = 1'b0;
            end
            @(negedge clk);
            if (active) cycles++;
            guard++;
        end
        if (guard >= 5000) begin
            tests++;
            fails++;
            $display("FAIL timeout: got active=%0d expected 0 after %0d cycles", active, guard);
        end
    endtask

    task automatic push_5x5();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                push(16'h1010 + 16'(r * 256 + c), 8'(r * 5 + c + 1));
    endtask

    int cnt;
    int cyc;

    initial begin
        for (int i = 0; i < 8192; i++) cram[i] = 8'(i + 1);
        rst_b       = 1'b0;
        cpu_ce_b    = 1'b1;
        cpu_we_b    = 1'b1;
        cpu_addr    = 13'd0;
        cpu_data    = 8'd0;
        free_vbus_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_we", {31'd0, dst_we_b}, 32'd1);
        #1 rst_b = 1'b1;
        @(negedge clk);
        check("post_rst_active", {31'd0, active}, 32'd0);
        check("post_rst_we", {31'd0, dst_we_b}, 32'd1);

        // 5x5 copy, data 1..25
        prog(16'h0000, 16'h1010, 8'd5, 8'd5, 8'hFF);
        push_5x5();
        do_start(1, 1'b1, cnt);
        run_xfer(cnt, -1, 16'h0, 8'h0, cyc);
        $display("[TB] 5x5 copy done in %0d cycles", cyc);
        check("copy_cycles", cyc, 32'd50);
        check("copy_drain", exp_q.size(), 32'd0);
        check("copy_idle", {31'd0, active}, 32'd0);

        // same copy with a 4-cycle video-bus stall on byte 1
        push_5x5();
        do_start(1, 1'b1, cnt);
        run_xfer(cnt, 3, 16'h1011, 8'h02, cyc);
        $display("[TB] stalled copy done in %0d cycles", cyc);
        check("stall_cycles", cyc, 32'd54);
        check("stall_drain", exp_q.size(), 32'd0);

        // zero width, then zero height
        prog(16'h0000, 16'h1010, 8'd0, 8'd3, 8'hFF);
        do_start(1, 1'b0, cnt);
        repeat (5) begin
            @(negedge clk);
            check("w0_idle", {31'd0, active}, 32'd0);
        end
        prog(16'h0000, 16'h1010, 8'd3, 8'd0, 8'hFF);
        do_start(3, 1'b0, cnt);
        repeat (5) begin
            @(negedge clk);
            check("h0_idle", {31'd0, active}, 32'd0);
        end
        $display("[TB] zero-size starts done");

        // mask: 0xF0 is transparent, 0x3C becomes 0x0C
        cram[13'h100] = 8'hF0;
        cram[13'h101] = 8'h3C;
        prog(16'h0100, 16'h2000, 8'd2, 8'd1, 8'h0F);
        push(16'h2001, 8'h0C);
        do_start(1, 1'b1, cnt);
        run_xfer(cnt, -1, 16'h0, 8'h0, cyc);
        $display("[TB] mask copy done in %0d cycles", cyc);
        check("mask_cycles", cyc, 32'd4);
        check("mask_drain", exp_q.size(), 32'd0);

        // strobe held 3 cycles; src wraps at 13 bits, dst low byte wraps
        prog(16'h1FFE, 16'h80FE, 8'd3, 8'd2, 8'hFF);
        push(16'h80FE, 8'hFF);
        push(16'h8000, 8'h01);
        push(16'h81FE, 8'h02);
        push(16'h81FF, 8'h03);
        push(16'h8100, 8'h04);
        do_start(3, 1'b1, cnt);
        run_xfer(cnt, -1, 16'h0, 8'h0, cyc);
        $display("[TB] held-start copy done in %0d cycles", cyc);
        check("hold_cycles", cyc, 32'd12);
        check("hold_drain", exp_q.size(), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("hold_no_retrigger", {31'd0, active}, 32'd0);
        end

        // asynchronous reset mid-copy, then a fresh transfer
        prog(16'h0000, 16'h1010, 8'd5, 8'd5, 8'hFF);
        push_5x5();
        do_start(1, 1'b1, cnt);
        repeat (10) @(negedge clk);
        #1 rst_b = 1'b0;
        #1;
        check("rst_mid_active", {31'd0, active}, 32'd0);
        check("rst_mid_we", {31'd0, dst_we_b}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        check("rst_hold_active", {31'd0, active}, 32'd0);
        #1 rst_b = 1'b1;
        $display("[TB] reset mid-copy released");
        cram[13'h10] = 8'h11;
        cram[13'h11] = 8'h12;
        cram[13'h12] = 8'h13;
        cram[13'h13] = 8'h14;
        prog(16'h0010, 16'h0505, 8'd2, 8'd2, 8'hFF);
        push(16'h0505, 8'h11);
        push(16'h0506, 8'h12);
        push(16'h0605, 8'h13);
        push(16'h0606, 8'h14);
        do_start(1, 1'b1, cnt);
        run_xfer(cnt, -1, 16'h0, 8'h0, cyc);
        $display("[TB] post-reset copy done in %0d cycles", cyc);
        check("after_rst_cycles", cyc, 32'd8);
        check("after_rst_drain", exp_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
